// File: rtl/mips_instr_encoder.sv
// mips_instr_encoder
// Program loader for the single-cycle core. It turns symbolic instructions
// (a mnemonic code plus register, shamt and immediate fields) into 32-bit MIPS
// words and writes them to consecutive instruction-memory word addresses,
// starting at 0 for each load session.
//
// Ports
//   clk          clock, all state updates on posedge
//   reset        synchronous, active-high
//   start        pulse: begin a new load session at address 0
//   in_valid     instruction fields valid
//   in_ready     encoder can accept (combinational from state/count/start)
//   mnem         mnemonic code 0..23 (24..31 illegal)
//   rs, rt, rd   register fields
//   shamt        shift amount
//   imm          immediate / branch word offset / lw-sw displacement
//   imem_we      write strobe, one cycle per word
//   imem_addr    word address of the current write
//   imem_wdata   encoded instruction
//   err_illegal  one-cycle pulse when an illegal mnemonic is consumed
//   full         DEPTH words accepted this session
//   word_count   words written this session
module mips_instr_encoder #(
  parameter int unsigned ADDR_W = 6,
  parameter int unsigned DEPTH  = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        mnem,
  input  logic [4:0]        rs,
  input  logic [4:0]        rt,
  input  logic [4:0]        rd,
  input  logic [4:0]        shamt,
  input  logic [15:0]       imm,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              err_illegal,
  output logic              full,
  output logic [ADDR_W:0]   word_count
);

  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C      = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] DEPTH_LAST_C = CNT_W'(DEPTH - 1);

  // R-type function codes
  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_SLLV = 6'h04;
  localparam logic [5:0] FN_SRLV = 6'h06;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  // I-type opcodes
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_SLTI = 6'h0A;
  localparam logic [5:0] OP_ANDI = 6'h0C;
  localparam logic [5:0] OP_ORI  = 6'h0D;
  localparam logic [5:0] OP_XORI = 6'h0E;
  localparam logic [5:0] OP_LUI  = 6'h0F;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_BNE  = 6'h05;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FULL = 2'd2
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [CNT_W-1:0]  r_acc, w_acc_nxt;
  logic [CNT_W-1:0]  r_wc, w_wc_nxt;
  logic              r_we, w_we_nxt;
  logic              r_err, w_err_nxt;
  logic [ADDR_W-1:0] r_addr, w_addr_nxt;
  logic [31:0]       r_wdata, w_wdata_nxt;

  logic              w_legal;
  logic [31:0]       w_word;
  logic              w_hs;

  function automatic logic [31:0] rtype(input logic [4:0] f_rs, input logic [4:0] f_rt,
                                        input logic [4:0] f_rd, input logic [4:0] f_sh,
                                        input logic [5:0] f_fn);
    return {6'b000000, f_rs, f_rt, f_rd, f_sh, f_fn};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] f_op, input logic [4:0] f_rs,
                                        input logic [4:0] f_rt, input logic [15:0] f_imm);
    return {f_op, f_rs, f_rt, f_imm};
  endfunction

  // Mnemonic to instruction word, with the per-instruction field forcing
  always_comb begin
    w_legal = 1'b1;
    w_word  = 32'h0000_0000;
    case (mnem)
      5'd0:  w_word = rtype(5'd0, rt, rd, shamt, FN_SLL);
      5'd1:  w_word = rtype(5'd0, rt, rd, shamt, FN_SRL);
      5'd2:  w_word = rtype(5'd0, rt, rd, shamt, FN_SRA);
      5'd3:  w_word = rtype(rs, rt, rd, 5'd0, FN_SLLV);
      5'd4:  w_word = rtype(rs, rt, rd, 5'd0, FN_SRLV);
      5'd5:  w_word = rtype(rs, 5'd0, 5'd0, 5'd0, FN_JR);
      5'd6:  w_word = rtype(rs, rt, rd, 5'd0, FN_ADD);
      5'd7:  w_word = rtype(rs, rt, rd, 5'd0, FN_SUB);
      5'd8:  w_word = rtype(rs, rt, rd, 5'd0, FN_AND);
      5'd9:  w_word = rtype(rs, rt, rd, 5'd0, FN_OR);
      5'd10: w_word = rtype(rs, rt, rd, 5'd0, FN_XOR);
      5'd11: w_word = rtype(rs, rt, rd, 5'd0, FN_NOR);
      5'd12: w_word = rtype(rs, rt, rd, 5'd0, FN_SLT);
      5'd13: w_word = rtype(rs, rt, rd, 5'd0, FN_SLTU);
      5'd14: w_word = itype(OP_ADDI, rs, rt, imm);
      5'd15: w_word = itype(OP_SLTI, rs, rt, imm);
      5'd16: w_word = itype(OP_ANDI, rs, rt, imm);
      5'd17: w_word = itype(OP_ORI, rs, rt, imm);
      5'd18: w_word = itype(OP_XORI, rs, rt, imm);
      5'd19: w_word = itype(OP_LUI, 5'd0, rt, imm);
      5'd20: w_word = itype(OP_LW, rs, rt, imm);
      5'd21: w_word = itype(OP_SW, rs, rt, imm);
      5'd22: w_word = itype(OP_BEQ, rs, rt, imm);
      5'd23: w_word = itype(OP_BNE, rs, rt, imm);
      default: w_legal = 1'b0;
    endcase
  end

  // Accept only while running, not on a start cycle, and below DEPTH
  assign in_ready = (r_state == S_RUN) && !start && (r_acc < DEPTH_C);
  assign w_hs     = in_valid && in_ready;

  // Next-state and registered-output logic
  always_comb begin
    w_state_nxt = r_state;
    w_acc_nxt   = r_acc;
    w_wc_nxt    = r_wc;
    w_we_nxt    = 1'b0;
    w_err_nxt   = 1'b0;
    w_addr_nxt  = r_addr;
    w_wdata_nxt = r_wdata;

    // word_count tracks writes already presented on the memory port
    if (r_we && (r_wc != DEPTH_C)) begin
      w_wc_nxt = r_wc + CNT_W'(1);
    end

    if (start) begin
      // New session from any state; a write in flight is not counted
      w_state_nxt = S_RUN;
      w_acc_nxt   = '0;
      w_wc_nxt    = '0;
      w_addr_nxt  = '0;
    end else begin
      case (r_state)
        S_RUN: begin
          if (w_hs) begin
            if (w_legal) begin
              w_we_nxt    = 1'b1;
              w_addr_nxt  = r_acc[ADDR_W-1:0];
              w_wdata_nxt = w_word;
              w_acc_nxt   = r_acc + CNT_W'(1);
              if (r_acc == DEPTH_LAST_C) begin
                w_state_nxt = S_FULL;
              end
            end else begin
              w_err_nxt = 1'b1;
            end
          end
        end
        S_FULL:  w_state_nxt = S_FULL;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_acc   <= '0;
      r_wc    <= '0;
      r_we    <= 1'b0;
      r_err   <= 1'b0;
      r_addr  <= '0;
      r_wdata <= 32'h0000_0000;
    end else begin
      r_state <= w_state_nxt;
      r_acc   <= w_acc_nxt;
      r_wc    <= w_wc_nxt;
      r_we    <= w_we_nxt;
      r_err   <= w_err_nxt;
      r_addr  <= w_addr_nxt;
      r_wdata <= w_wdata_nxt;
    end
  end

  assign imem_we     = r_we;
  assign imem_addr   = r_addr;
  assign imem_wdata  = r_wdata;
  assign err_illegal = r_err;
  assign full        = (r_state == S_FULL);
  assign word_count  = r_wc;

endmodule

// File: tb/tb_mips_instr_encoder.sv
// Bench for mips_instr_encoder: directed literal checks plus a randomized run
// checked every cycle against a behavioural model of the loader.
module tb_mips_instr_encoder;

  localparam int unsigned ADDR_W = 6;
  localparam int unsigned DEPTH  = 4;

  logic              clk;
  logic              reset;
  logic              start;
  logic              in_valid;
  logic              in_ready;
  logic [4:0]        mnem;
  logic [4:0]        rs;
  logic [4:0]        rt;
  logic [4:0]        rd;
  logic [4:0]        shamt;
  logic [15:0]       imm;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              err_illegal;
  logic              full;
  logic [ADDR_W:0]   word_count;

  int n_cmp = 0;
  int n_bad = 0;

  mips_instr_encoder #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .mnem(mnem), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .imm(imm),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .err_illegal(err_illegal), .full(full), .word_count(word_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Function codes for mnemonics 0..13 and opcodes for 14..23
  int unsigned funct_tab [0:13] = '{'h00, 'h02, 'h03, 'h04, 'h06, 'h08, 'h20,
                                    'h22, 'h24, 'h25, 'h26, 'h27, 'h2A, 'h2B};
  int unsigned op_tab [0:9] = '{'h08, 'h0A, 'h0C, 'h0D, 'h0E, 'h0F, 'h23, 'h2B, 'h04, 'h05};

  function automatic logic [31:0] enc(input int m, input int unsigned a_rs, input int unsigned a_rt,
                                      input int unsigned a_rd, input int unsigned a_sh,
                                      input int unsigned a_imm);
    int unsigned v_rs, v_rt, v_rd, v_sh;
    if (m <= 13) begin
      v_rs = (m <= 2) ? 0 : a_rs;
      v_rt = (m == 5) ? 0 : a_rt;
      v_rd = (m == 5) ? 0 : a_rd;
      v_sh = (m <= 2) ? a_sh : 0;
      return 32'(v_rs * (2 ** 21) + v_rt * (2 ** 16) + v_rd * (2 ** 11) + v_sh * (2 ** 6)
                 + funct_tab[m]);
    end
    v_rs = (m == 19) ? 0 : a_rs;
    return 32'(op_tab[m - 14] * (2 ** 26) + v_rs * (2 ** 21) + a_rt * (2 ** 16) + a_imm);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: session state, accept count and expected outputs
  int        m_state = 0;  // 0 idle, 1 running, 2 full
  int        m_acc   = 0;
  int        m_wc    = 0;
  bit        m_we    = 1'b0;
  bit        m_err   = 1'b0;
  int        m_addr  = 0;
  logic [31:0] m_wd  = 32'h0;
  bit        armed   = 1'b0;

  always @(negedge clk) begin
    bit rdy;
    int nwc;
    rdy = (m_state == 1) && !start && (m_acc < DEPTH);
    if (armed) begin
      chk("m_in_ready", 32'(in_ready), 32'(rdy));
      chk("m_we", 32'(imem_we), 32'(m_we));
      chk("m_err", 32'(err_illegal), 32'(m_err));
      chk("m_full", 32'(full), 32'(m_state == 2));
      chk("m_word_count", 32'(word_count), 32'(m_wc));
      if (m_we) begin
        chk("m_addr", 32'(imem_addr), 32'(m_addr));
        chk("m_wdata", imem_wdata, m_wd);
      end
    end
    if (reset) begin
      m_state = 0; m_acc = 0; m_wc = 0; m_we = 1'b0; m_err = 1'b0;
      m_addr = 0; m_wd = 32'h0; armed = 1'b1;
    end else begin
      nwc = start ? 0 : (m_we ? m_wc + 1 : m_wc);
      m_we = 1'b0;
      m_err = 1'b0;
      if (start) begin
        m_state = 1; m_acc = 0; m_addr = 0;
      end else if (in_valid && rdy) begin
        if (int'(mnem) < 24) begin
          m_we = 1'b1;
          m_addr = m_acc;
          m_wd = enc(int'(mnem), rs, rt, rd, shamt, imm);
          m_acc++;
          if (m_acc == DEPTH) m_state = 2;
        end else begin
          m_err = 1'b1;
        end
      end
      m_wc = nwc;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_fields(input int m, input int a_rs, input int a_rt, input int a_rd,
                            input int a_sh, input int a_imm);
    mnem = 5'(m); rs = 5'(a_rs); rt = 5'(a_rt); rd = 5'(a_rd); shamt = 5'(a_sh);
    imm = 16'(a_imm);
  endtask

  task automatic send(input int m, input int a_rs, input int a_rt, input int a_rd,
                      input int a_sh, input int a_imm);
    set_fields(m, a_rs, a_rt, a_rd, a_sh, a_imm);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; in_valid = 1'b0;
    set_fields(0, 0, 0, 0, 0, 0);

    // Pin the model's encoder to hand-computed words
    chk("pin_add", enc(6, 1, 2, 3, 0, 0), 32'h0022_1820);
    chk("pin_sll", enc(0, 7, 3, 2, 4, 0), 32'h0003_1100);
    chk("pin_addi", enc(14, 0, 2, 0, 0, 5), 32'h2002_0005);
    chk("pin_lw", enc(20, 5, 4, 0, 0, 8), 32'h8CA4_0008);
    chk("pin_beq", enc(22, 1, 2, 0, 0, 'hFFFF), 32'h1022_FFFF);
    chk("pin_jr", enc(5, 31, 9, 9, 9, 0), 32'h03E0_0008);
    chk("pin_lui", enc(19, 7, 1, 0, 0, 'h1234), 32'h3C01_1234);

    step(); step();
    chk("rst_we", 32'(imem_we), 32'd0);
    chk("rst_addr", 32'(imem_addr), 32'd0);
    chk("rst_wdata", imem_wdata, 32'd0);
    chk("rst_err", 32'(err_illegal), 32'd0);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_wc", 32'(word_count), 32'd0);
    chk("rst_ready", 32'(in_ready), 32'd0);
    reset = 1'b0;
    step();

    // add, sll, addi
    pulse_start();
    send(6, 1, 2, 3, 0, 0);
    chk("add_we", 32'(imem_we), 32'd1);
    chk("add_addr", 32'(imem_addr), 32'd0);
    chk("add_wdata", imem_wdata, 32'h0022_1820);
    send(0, 7, 3, 2, 4, 0);
    chk("sll_addr", 32'(imem_addr), 32'd1);
    chk("sll_wdata", imem_wdata, 32'h0003_1100);
    send(14, 0, 2, 0, 0, 5);
    chk("addi_addr", 32'(imem_addr), 32'd2);
    chk("addi_wdata", imem_wdata, 32'h2002_0005);

    // back-to-back lw, beq
    pulse_start();
    set_fields(20, 5, 4, 0, 0, 8);
    in_valid = 1'b1;
    step();
    chk("lw_addr", 32'(imem_addr), 32'd0);
    chk("lw_wdata", imem_wdata, 32'h8CA4_0008);
    set_fields(22, 1, 2, 0, 0, 'hFFFF);
    step();
    chk("beq_we", 32'(imem_we), 32'd1);
    chk("beq_addr", 32'(imem_addr), 32'd1);
    chk("beq_wdata", imem_wdata, 32'h1022_FFFF);
    in_valid = 1'b0;
    step();
    chk("b2b_wc", 32'(word_count), 32'd2);

    // illegal mnemonic
    send(27, 1, 1, 1, 1, 1);
    chk("ill_err", 32'(err_illegal), 32'd1);
    chk("ill_we", 32'(imem_we), 32'd0);
    step();
    chk("ill_err_pulse", 32'(err_illegal), 32'd0);
    chk("ill_wc", 32'(word_count), 32'd2);
    send(6, 1, 2, 3, 0, 0);
    chk("ill_next_addr", 32'(imem_addr), 32'd2);

    // fill to DEPTH with in_valid held high
    pulse_start();
    in_valid = 1'b1;
    for (int i = 1; i <= DEPTH + 2; i++) begin
      set_fields($urandom_range(0, 23), $urandom_range(0, 31), $urandom_range(0, 31),
                 $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 65535));
      step();
      if (i <= DEPTH) begin
        chk("fill_we", 32'(imem_we), 32'd1);
        chk("fill_addr", 32'(imem_addr), 32'(i - 1));
      end else begin
        chk("fill_no_we", 32'(imem_we), 32'd0);
      end
      if (i >= DEPTH) begin
        chk("fill_full", 32'(full), 32'd1);
        chk("fill_ready", 32'(in_ready), 32'd0);
      end
    end
    in_valid = 1'b0;
    step();
    chk("fill_wc_sat", 32'(word_count), 32'(DEPTH));
    pulse_start();
    chk("restart_full", 32'(full), 32'd0);
    send(9, 4, 5, 6, 0, 0);
    chk("restart_addr", 32'(imem_addr), 32'd0);

    // start / reset right after an accept
    send(6, 1, 2, 3, 0, 0);
    pulse_start();
    chk("st_drop_we", 32'(imem_we), 32'd0);
    chk("st_drop_wc", 32'(word_count), 32'd0);
    send(7, 1, 2, 3, 0, 0);
    chk("st_next_addr", 32'(imem_addr), 32'd0);
    send(8, 1, 2, 3, 0, 0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rs_drop_we", 32'(imem_we), 32'd0);
    chk("rs_drop_wc", 32'(word_count), 32'd0);
    chk("rs_ready", 32'(in_ready), 32'd0);

    // randomized traffic checked by the model
    for (int c = 0; c < 3000; c++) begin
      reset    = ($urandom_range(0, 199) == 0);
      start    = ($urandom_range(0, 24) == 0);
      in_valid = ($urandom_range(0, 9) < 7);
      set_fields($urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
                 $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 65535));
      step();
    end
    reset = 1'b0; start = 1'b0; in_valid = 1'b0;
    step(); step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
